mc_control: RTL
===============

# mc_control

Multicycle control FSM for the 8-bit RISC-V datapath. Sequences fetch, decode, execute, memory and write-back for the supported subset (R-type ALU, I-type ALU, lw, sw, beq), and drives every datapath mux select and register write enable. Memory accesses are stretched by a ready handshake. Sits beside the datapath; decodes opcode/funct fields from the instruction register.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high; forces state to FETCH
- opcode  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes current access this cycle
- IorD  out  1  address mux: 1 = ALUOut, 0 = PC
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC (unconditional or branch-qualified)
- PCSource  out  1  PC mux: 1 = ALUOut, 0 = ALUResult
- ALUSrcA  out  1  1 = A register, 0 = PC
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = Imm
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
- MemtoReg  out  1  write-back mux: 1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse on unsupported instruction
- state  out  4  current state encoding (debug)

## Operation
- States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9. Codes 10–15 → FETCH next cycle, all enables 0.
- Outputs are combinational from state, opcode/funct, zero, mem_ready. Unlisted outputs default 0 (ALUControl = ADD, ALUSrcB = 00).
- FETCH: IorD=0, mem_read=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=0. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; → DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=10, ADD (ALUOut ← PC+Imm, branch target; offsets are PC+4-relative in this core). Next: 0000011/0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; else illegal_op=1, → FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: IorD=1, mem_read=1; wait for mem_ready → MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1 → FETCH.
- MEMWRITE: IorD=1, mem_write=1; wait for mem_ready → FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl per funct → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUControl per funct3 (funct7b5 ignored) → ALU_WB.
- ALU_WB: MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=1, PCWrite=zero → FETCH.
- Funct decode: 000 → ADD (R-type with funct7b5=1 → SUB), 111 AND, 110 OR, 100 XOR, 010 SLT. Any other funct3 in R/I-type: illegal_op pulses in DECODE, → FETCH. beq requires funct3=000, else illegal.

## Timing
- Reset: state=FETCH immediately (async); while reset high PCWrite, IRWrite, RegWrite, mem_write, mem_read, illegal_op all forced 0. First fetch request the cycle after reset deasserts.
- Latency with mem_ready constantly 1: beq 3 cycles, R/I-type 4, sw 4, lw 5.
- Each cycle mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one cycle; outputs held stable while waiting; no PC/IR update until ready.
- mem_ready ignored outside FETCH, MEMREAD, MEMWRITE.
- Reset mid-instruction: abandon immediately, no partial RegWrite/mem_write after reset asserts.
- illegal_op is exactly one cycle wide; no architectural state written for illegal instructions.

## Test plan
- Reset held 3 cycles mid-MEMREAD -> state=0, all enables 0; first cycle after release mem_read=1, IorD=0.
- add (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states 0,1,6,8,0; ALUControl=000 in EXEC_R; RegWrite=1, MemtoReg=0 only in ALU_WB.
- sub (funct7b5=1) then slt I-type (0010011, funct3 010) -> ALUControl 001 in EXEC_R, 101 in EXEC_I with ALUSrcB=10.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> total 10 cycles; PCWrite/IRWrite high only in ready FETCH cycle; MemtoReg=RegWrite=1 in MEMWB.
- beq with zero=1 then zero=0 -> PCWrite=1, PCSource=1 in BRANCH for first; PCWrite=0 for second; both return to FETCH after 3 cycles.
- opcode 1101111 and R-type funct3 001 -> illegal_op one-cycle pulse in DECODE, no RegWrite/mem_write, next state FETCH.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle control FSM for the 8-bit RISC-V datapath: sequences fetch through
// write-back for R/I-type ALU ops, lw, sw and beq, stretching memory states on mem_ready.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t state_q, state_d;
  alu_t   alu_fn;
  logic   fn_ok;
  logic   ill_raw;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // funct7b5 only selects SUB for R-type; immediate forms ignore it.
  always_comb begin
    alu_fn = ALU_ADD;
    fn_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_fn = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b100:  alu_fn = ALU_XOR;
      3'b010:  alu_fn = ALU_SLT;
      default: fn_ok  = 1'b0;
    endcase
  end

  // NOTE: every output and next-state is assigned a default before the case so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = S_FETCH;
    IorD       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ill_raw    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        state_d  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the register file is read.
        ALUSrcB = 2'b10;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:   if (fn_ok) state_d = S_EXEC_R; else ill_raw = 1'b1;
          OP_I:   if (fn_ok) state_d = S_EXEC_I; else ill_raw = 1'b1;
          OP_BEQ: if (funct3 == 3'b000) state_d = S_BRANCH; else ill_raw = 1'b1;
          default: ill_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_fn;
        state_d    = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = alu_fn;
        state_d    = S_ALU_WB;
      end
      S_ALU_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSource   = 1'b1;
        PCWrite    = zero;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks all write/request strobes even though state already reads FETCH.
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ill_raw   = 1'b0;
    end
  end

  assign illegal_op = ill_raw;
  assign state      = state_q;

endmodule
